// File: rtl/psb_pkg.sv
// rtl/psb_pkg.sv - shared types and pointer helper for the parametric store buffer
package psb_pkg;

  localparam int SB_AW_MAX = 62;
  localparam int DEPTH_DEF = 16;
  localparam int PW        = $clog2(DEPTH_DEF);

  // addr is held at its widest legal size so one struct serves every PHYS
  typedef struct packed {
    logic [SB_AW_MAX-1:0] addr;
    logic [31:0]          data;
    logic [3:0]           bm;
    logic                 io;
  } sb_entry_t;

  function automatic int ptr_add(input int ptr, input int k, input int depth);
    return (ptr + k) % depth;
  endfunction

endpackage

// File: rtl/parametric_store_buffer_if.sv
// rtl/parametric_store_buffer_if.sv - store enqueue handshake and completion notification
interface parametric_store_buffer_if #(
  parameter int PHYS = 32,
  parameter int ROBW = 5
);
  logic            enq_valid_i;
  logic            enq_ready_o;
  logic [PHYS-3:0] enq_addr_i;
  logic [31:0]     enq_data_i;
  logic [3:0]      enq_bm_i;
  logic            enq_io_i;
  logic [ROBW-1:0] enq_rob_i;
  logic            complete_vld_o;
  logic [ROBW-1:0] complete_rob_o;

  modport master (
    output enq_valid_i, enq_addr_i, enq_data_i, enq_bm_i, enq_io_i, enq_rob_i,
    input  enq_ready_o, complete_vld_o, complete_rob_o
  );

  modport slave (
    input  enq_valid_i, enq_addr_i, enq_data_i, enq_bm_i, enq_io_i, enq_rob_i,
    output enq_ready_o, complete_vld_o, complete_rob_o
  );
endinterface

// File: rtl/psb_youngest_sel.sv
// rtl/psb_youngest_sel.sv - one-hot pick of the youngest set bit, age measured from head
module psb_youngest_sel #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match,
  input  logic [PTR_W-1:0] head,
  output logic [DEPTH-1:0] onehot
);

  logic [DEPTH-1:0] rot;
  logic [DEPTH-1:0] pick;
  logic             found;
  int               idx;

  // rot[j] is the entry of age j; the highest set age wins
  always_comb begin
    rot    = '0;
    pick   = '0;
    onehot = '0;
    found  = 1'b0;
    idx    = 0;
    for (int j = 0; j < DEPTH; j++) begin
      idx = j + int'(head);
      if (idx >= DEPTH) idx = idx - DEPTH;
      rot[j] = match[PTR_W'(idx)];
    end
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (rot[j] && !found) begin
        pick[j] = 1'b1;
        found   = 1'b1;
      end
    end
    for (int j = 0; j < DEPTH; j++) begin
      idx = j + int'(head);
      if (idx >= DEPTH) idx = idx - DEPTH;
      onehot[PTR_W'(idx)] = pick[j];
    end
  end

endmodule

// File: rtl/parametric_store_buffer.sv
// rtl/parametric_store_buffer.sv - circular store buffer with byte forwarding and in-order drain
module parametric_store_buffer
  import psb_pkg::*;
#(
  parameter int PHYS     = 32,
  parameter int DEPTH    = 16,
  parameter int COMMIT_W = 2,
  parameter int ROBW     = 5
) (
  input  logic                cpu_clk_i,
  input  logic                cpu_rst_i,
  input  logic                flush_i,
  parametric_store_buffer_if.slave enq,
  input  logic [COMMIT_W-1:0] commit_i,
  input  logic [PHYS-3:0]     fwd_addr_i,
  input  logic [3:0]          fwd_bm_i,
  output logic [31:0]         fwd_data_o,
  output logic [3:0]          fwd_bm_o,
  output logic                fwd_hit_o,
  output logic                fwd_full_o,
  output logic [PHYS-3:0]     store_addr_o,
  output logic [31:0]         store_data_o,
  output logic [3:0]          store_bm_o,
  output logic                store_valid_o,
  input  logic                cache_done_i,
  output logic                no_nonspec_o,
  output logic                empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = PHYS - 2;

  sb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head, cptr, tail;
  logic [CNT_W-1:0] ncnt, scnt, occ, k;
  logic             accept, drain_done;
  logic [DEPTH-1:0] valid, io_match;
  logic [DEPTH-1:0] match [4];
  logic [DEPTH-1:0] win   [4];
  int               pc, age;

  // readiness looks only at registered counts, never at this cycle's drain
  assign occ                = ncnt + scnt;
  assign enq.enq_ready_o    = (occ != CNT_W'(DEPTH)) && !cpu_rst_i;
  assign accept             = enq.enq_valid_i && enq.enq_ready_o && !flush_i;
  assign enq.complete_vld_o = accept;
  assign enq.complete_rob_o = ROBW'(enq.enq_rob_i);
  assign drain_done         = store_valid_o && cache_done_i;
  assign no_nonspec_o       = (ncnt == '0);
  assign empty_o            = (occ == '0);

  always_comb begin
    pc = $countones(commit_i);
    k  = (pc > int'(scnt)) ? scnt : CNT_W'(pc);
  end

  always_comb begin
    valid    = '0;
    io_match = '0;
    age      = 0;
    for (int i = 0; i < DEPTH; i++) begin
      age = i - int'(head);
      if (age < 0) age = age + DEPTH;
      valid[i] = !cpu_rst_i && (age < int'(occ));
    end
    for (int b = 0; b < 4; b++) begin
      match[b] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        match[b][i] = valid[i] && (mem[i].addr == SB_AW_MAX'(fwd_addr_i))
                      && mem[i].bm[b] && fwd_bm_i[b];
        io_match[i] = io_match[i] | (match[b][i] & mem[i].io);
      end
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_byte
    psb_youngest_sel #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_sel (
      .match  (match[b]),
      .head   (head),
      .onehot (win[b])
    );
  end

  always_comb begin
    fwd_data_o = '0;
    fwd_bm_o   = '0;
    for (int b = 0; b < 4; b++) begin
      fwd_bm_o[b] = |match[b];
      for (int i = 0; i < DEPTH; i++) begin
        if (win[b][i]) fwd_data_o[8*b +: 8] = mem[i].data[8*b +: 8];
      end
    end
  end

  assign fwd_hit_o  = |fwd_bm_o;
  assign fwd_full_o = fwd_hit_o && (fwd_bm_o == fwd_bm_i) && !(|io_match);

  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      head          <= '0;
      cptr          <= '0;
      tail          <= '0;
      ncnt          <= '0;
      scnt          <= '0;
      store_valid_o <= 1'b0;
      store_addr_o  <= '0;
      store_data_o  <= '0;
      store_bm_o    <= '0;
    end else begin
      if (accept) begin
        mem[tail] <= '{addr: SB_AW_MAX'(enq.enq_addr_i), data: enq.enq_data_i,
                       bm: enq.enq_bm_i, io: enq.enq_io_i};
      end
      cptr <= PTR_W'(ptr_add(int'(cptr), int'(k), DEPTH));
      // flush rewinds to the commit point as it stands after this cycle's commit
      if (flush_i) begin
        tail <= PTR_W'(ptr_add(int'(cptr), int'(k), DEPTH));
        scnt <= '0;
      end else begin
        if (accept) tail <= PTR_W'(ptr_add(int'(tail), 1, DEPTH));
        scnt <= scnt - k + CNT_W'(accept);
      end
      ncnt <= ncnt + k - CNT_W'(drain_done);
      if (drain_done) begin
        head          <= PTR_W'(ptr_add(int'(head), 1, DEPTH));
        store_valid_o <= 1'b0;
      end else if (!store_valid_o && ncnt != '0) begin
        store_addr_o  <= mem[head].addr[AW-1:0];
        store_data_o  <= mem[head].data;
        store_bm_o    <= mem[head].bm;
        store_valid_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parametric_store_buffer.sv
// tb/tb_parametric_store_buffer.sv - directed self-checking bench for parametric_store_buffer
module tb_parametric_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  commit;
  logic [29:0] fwd_addr;
  logic [3:0]  fwd_bm;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_bm_out;
  logic        fwd_hit, fwd_full;
  logic [29:0] store_addr;
  logic [31:0] store_data;
  logic [3:0]  store_bm;
  logic        store_valid, cache_done, no_nonspec, empty;

  int nvec = 0;
  int nerr = 0;
  int m_s  = 0;

  parametric_store_buffer_if #(.PHYS(32), .ROBW(5)) enq_bus ();

  parametric_store_buffer #(.PHYS(32), .DEPTH(16), .COMMIT_W(2), .ROBW(5)) dut (
    .cpu_clk_i     (clk),
    .cpu_rst_i     (rst),
    .flush_i       (flush),
    .enq           (enq_bus),
    .commit_i      (commit),
    .fwd_addr_i    (fwd_addr),
    .fwd_bm_i      (fwd_bm),
    .fwd_data_o    (fwd_data),
    .fwd_bm_o      (fwd_bm_out),
    .fwd_hit_o     (fwd_hit),
    .fwd_full_o    (fwd_full),
    .store_addr_o  (store_addr),
    .store_data_o  (store_data),
    .store_bm_o    (store_bm),
    .store_valid_o (store_valid),
    .cache_done_i  (cache_done),
    .no_nonspec_o  (no_nonspec),
    .empty_o       (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    flush                   = 1'b0;
    commit                  = 2'b00;
    cache_done              = 1'b0;
    fwd_addr                = '0;
    fwd_bm                  = '0;
    enq_bus.enq_valid_i     = 1'b0;
    enq_bus.enq_addr_i      = '0;
    enq_bus.enq_data_i      = '0;
    enq_bus.enq_bm_i        = '0;
    enq_bus.enq_io_i        = 1'b0;
    enq_bus.enq_rob_i       = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    rst = 1'b0;
    m_s = 0;
  endtask

  task automatic enq_push(input logic [29:0] a, input logic [31:0] d, input logic [3:0] bm,
                          input logic io, input logic [4:0] rob);
    enq_bus.enq_valid_i = 1'b1;
    enq_bus.enq_addr_i  = a;
    enq_bus.enq_data_i  = d;
    enq_bus.enq_bm_i    = bm;
    enq_bus.enq_io_i    = io;
    enq_bus.enq_rob_i   = rob;
    #1;
    check_vec("enq_complete", 64'(enq_bus.complete_vld_o), 64'd1);
    check_vec("enq_rob", 64'(enq_bus.complete_rob_o), 64'(rob));
    tick();
    enq_bus.enq_valid_i = 1'b0;
    m_s++;
  endtask

  task automatic set_commit(input logic [1:0] c);
    assert ($countones(c) <= m_s) else $error("commit exceeds speculative count");
    commit = c;
    m_s    = m_s - $countones(c);
  endtask

  task automatic query(input string tag, input logic [29:0] a, input logic [3:0] bm,
                       input logic [31:0] ed, input logic [3:0] ebm, input logic eh, input logic ef);
    fwd_addr = a;
    fwd_bm   = bm;
    #1;
    check_vec({tag, "_data"}, 64'(fwd_data), 64'(ed));
    check_vec({tag, "_bm"}, 64'(fwd_bm_out), 64'(ebm));
    check_vec({tag, "_hit"}, 64'(fwd_hit), 64'(eh));
    check_vec({tag, "_full"}, 64'(fwd_full), 64'(ef));
  endtask

  // five stores, commit two while flushing the rest, then drain both with a slow cache
  task automatic flush_round(input logic [29:0] base);
    for (int i = 0; i < 5; i++) enq_push(base + 30'(i), 32'hC0DE0000 | 32'(base + 30'(i)), 4'hF, 1'b0, 5'(i));
    set_commit(2'b11);
    flush = 1'b1;
    enq_bus.enq_valid_i = 1'b1;
    enq_bus.enq_addr_i  = base + 30'd7;
    #1;
    check_vec("flush_enq_drop", 64'(enq_bus.complete_vld_o), 64'd0);
    tick();
    commit = 2'b00;
    flush  = 1'b0;
    enq_bus.enq_valid_i = 1'b0;
    m_s = 0;
    check_vec("flush_no_issue_yet", 64'(store_valid), 64'd0);
    check_vec("flush_nonspec", 64'(no_nonspec), 64'd0);
    query("flush_kept", base + 30'd1, 4'hF, 32'hC0DE0000 | 32'(base + 30'd1), 4'hF, 1'b1, 1'b1);
    query("flush_gone", base + 30'd2, 4'hF, 32'h0, 4'h0, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      tick();
      check_vec("drain_valid", 64'(store_valid), 64'd1);
      check_vec("drain_addr", 64'(store_addr), 64'(base + 30'(d)));
      check_vec("drain_data", 64'(store_data), 64'(32'hC0DE0000 | 32'(base + 30'(d))));
      for (int w = 0; w < 3; w++) begin
        tick();
        check_vec("drain_hold", 64'(store_valid), 64'd1);
      end
      cache_done = 1'b1;
      tick();
      cache_done = 1'b0;
      check_vec("drain_bubble", 64'(store_valid), 64'd0);
    end
    check_vec("round_nonspec", 64'(no_nonspec), 64'd1);
    check_vec("round_empty", 64'(empty), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    enq_bus.enq_valid_i = 1'b1;
    tick();
    tick();
    check_vec("rst_ready", 64'(enq_bus.enq_ready_o), 64'd0);
    check_vec("rst_complete", 64'(enq_bus.complete_vld_o), 64'd0);
    check_vec("rst_store_valid", 64'(store_valid), 64'd0);
    check_vec("rst_empty", 64'(empty), 64'd1);
    check_vec("rst_nonspec", 64'(no_nonspec), 64'd1);
    check_vec("rst_hit", 64'(fwd_hit), 64'd0);
    do_reset();

    // fill to capacity, 17th held
    for (int i = 0; i < 16; i++) enq_push(30'h100 + 30'(i), 32'hA0000000 | 32'(i), 4'hF, 1'b0, 5'(i + 3));
    enq_bus.enq_valid_i = 1'b1;
    #1;
    check_vec("full_ready", 64'(enq_bus.enq_ready_o), 64'd0);
    check_vec("full_complete", 64'(enq_bus.complete_vld_o), 64'd0);
    check_vec("full_empty", 64'(empty), 64'd0);
    check_vec("full_nonspec", 64'(no_nonspec), 64'd1);
    enq_bus.enq_valid_i = 1'b0;
    query("full_fwd", 30'h105, 4'hF, 32'hA0000005, 4'hF, 1'b1, 1'b1);
    do_reset();

    // per-byte merge, youngest wins, and I/O blocking
    enq_push(30'h40, 32'h0000BBAA, 4'b0011, 1'b0, 5'd1);
    enq_push(30'h40, 32'h00DDCC00, 4'b0110, 1'b0, 5'd2);
    enq_push(30'h80, 32'h11223344, 4'b1111, 1'b1, 5'd3);
    query("merge_all", 30'h40, 4'hF, 32'h00DDCCAA, 4'b0111, 1'b1, 1'b0);
    query("merge_low", 30'h40, 4'b0011, 32'h0000CCAA, 4'b0011, 1'b1, 1'b1);
    query("io_block", 30'h80, 4'b0001, 32'h00000044, 4'b0001, 1'b1, 1'b0);
    query("miss_addr", 30'h99, 4'hF, 32'h0, 4'h0, 1'b0, 1'b0);
    query("miss_byte", 30'h40, 4'b1000, 32'h0, 4'h0, 1'b0, 1'b0);
    do_reset();

    // enqueue, commit and cache_done in one cycle
    enq_push(30'h500, 32'h5000, 4'hF, 1'b0, 5'd0);
    enq_push(30'h501, 32'h5001, 4'hF, 1'b0, 5'd1);
    set_commit(2'b01);
    tick();
    commit = 2'b00;
    check_vec("sim_no_issue_yet", 64'(store_valid), 64'd0);
    tick();
    check_vec("sim_issue0", 64'(store_valid), 64'd1);
    check_vec("sim_addr0", 64'(store_addr), 64'h500);
    enq_bus.enq_valid_i = 1'b1;
    enq_bus.enq_addr_i  = 30'h502;
    enq_bus.enq_data_i  = 32'h5002;
    enq_bus.enq_bm_i    = 4'hF;
    enq_bus.enq_io_i    = 1'b0;
    set_commit(2'b01);
    cache_done = 1'b1;
    #1;
    check_vec("sim_complete", 64'(enq_bus.complete_vld_o), 64'd1);
    tick();
    m_s++;
    enq_bus.enq_valid_i = 1'b0;
    commit     = 2'b00;
    cache_done = 1'b0;
    check_vec("sim_bubble", 64'(store_valid), 64'd0);
    check_vec("sim_nonspec", 64'(no_nonspec), 64'd0);
    check_vec("sim_empty", 64'(empty), 64'd0);
    tick();
    check_vec("sim_issue1", 64'(store_valid), 64'd1);
    check_vec("sim_addr1", 64'(store_addr), 64'h501);
    cache_done = 1'b1;
    tick();
    cache_done = 1'b0;
    check_vec("sim_done_nonspec", 64'(no_nonspec), 64'd1);
    check_vec("sim_done_empty", 64'(empty), 64'd0);
    query("sim_fwd", 30'h502, 4'hF, 32'h5002, 4'hF, 1'b1, 1'b1);
    do_reset();

    // drain while full, then reset during an in-flight write
    for (int i = 0; i < 16; i++) enq_push(30'h600 + 30'(i), 32'h6000 + 32'(i), 4'hF, 1'b0, 5'(i));
    set_commit(2'b11);
    tick();
    commit = 2'b00;
    tick();
    check_vec("fd_issue0", 64'(store_valid), 64'd1);
    check_vec("fd_addr0", 64'(store_addr), 64'h600);
    enq_bus.enq_valid_i = 1'b1;
    enq_bus.enq_addr_i  = 30'h6FF;
    cache_done = 1'b1;
    #1;
    check_vec("fd_ready_held", 64'(enq_bus.enq_ready_o), 64'd0);
    check_vec("fd_complete_held", 64'(enq_bus.complete_vld_o), 64'd0);
    tick();
    enq_bus.enq_valid_i = 1'b0;
    cache_done = 1'b0;
    check_vec("fd_ready_after", 64'(enq_bus.enq_ready_o), 64'd1);
    check_vec("fd_bubble", 64'(store_valid), 64'd0);
    tick();
    check_vec("fd_issue1", 64'(store_valid), 64'd1);
    check_vec("fd_addr1", 64'(store_addr), 64'h601);
    rst = 1'b1;
    cache_done = 1'b1;
    enq_bus.enq_valid_i = 1'b1;
    #1;
    check_vec("mr_ready", 64'(enq_bus.enq_ready_o), 64'd0);
    check_vec("mr_complete", 64'(enq_bus.complete_vld_o), 64'd0);
    tick();
    check_vec("mr_store_valid", 64'(store_valid), 64'd0);
    check_vec("mr_store_addr", 64'(store_addr), 64'd0);
    check_vec("mr_empty", 64'(empty), 64'd1);
    check_vec("mr_nonspec", 64'(no_nonspec), 64'd1);
    query("mr_fwd", 30'h601, 4'hF, 32'h0, 4'h0, 1'b0, 1'b0);
    do_reset();

    // commit+flush rounds, enough to wrap all three pointers
    for (int r = 0; r < 10; r++) flush_round(30'h200 + 30'(r * 16));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
